// File: rtl/fpu_job_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_job_sequencer
//
// Control FSM between the host control interface and the per-unit
// operand/output registers. A rising edge on the host doorbell starts a job.
// The FSM then emits one issue pulse per lane: one lane for a scalar job, or
// fpu_simd_no_op+1 lanes for a SIMD job. After each issue it waits for the
// unit's ready pulse, accumulates the flags and enforces a per-lane timeout.
// At job end it raises fpu_ready, requests a doorbell clear and optionally
// pulses the interrupt.
//
// Ports
//   clk              clock, rising edge
//   reset            asynchronous active-high reset
//   fpu_rst_w        synchronous soft reset, overrides every other input
//   fpu_en           FPU enable, only looked at on a doorbell edge
//   fpu_doorbell_w   host doorbell level
//   fpu_int_en       interrupt enable, sampled on entry to DONE
//   fpu_simd         SIMD job select, latched at start
//   fpu_simd_no_op   SIMD lane count minus one, latched at start
//   unit_ready       ready pulse from the selected unit
//   unit_flags       {invalid, overflow, underflow, inexact}, qualified by ready
//   issue            one-cycle issue pulse to the operand register
//   lane_sel         current lane index
//   busy             high while in ISSUE or WAIT
//   fpu_ready        job-complete level
//   fpu_doorbell_r   one-cycle doorbell clear request
//   fpu_interrupt_w  one-cycle completion interrupt
//   job_flags        sticky OR of unit_flags over the job
//   timeout_err      sticky, set when the job ended by timeout
// -----------------------------------------------------------------------------
module fpu_job_sequencer #(
    parameter int LANES_MAX      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fpu_rst_w,
    input  logic                         fpu_en,
    input  logic                         fpu_doorbell_w,
    input  logic                         fpu_int_en,
    input  logic                         fpu_simd,
    input  logic [$clog2(LANES_MAX)-1:0] fpu_simd_no_op,
    input  logic                         unit_ready,
    input  logic [3:0]                   unit_flags,
    output logic                         issue,
    output logic [$clog2(LANES_MAX)-1:0] lane_sel,
    output logic                         busy,
    output logic                         fpu_ready,
    output logic                         fpu_doorbell_r,
    output logic                         fpu_interrupt_w,
    output logic [3:0]                   job_flags,
    output logic                         timeout_err
);

    localparam int         LANE_W     = $clog2(LANES_MAX);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                doorbell_d;
    logic                start;
    logic [LANE_W-1:0]   last_lane;
    logic [7:0]          timer;

    logic [LANE_W-1:0]   lane_nxt;
    logic [LANE_W-1:0]   last_nxt;
    logic [7:0]          timer_nxt;
    logic [3:0]          flags_nxt;
    logic                tmo_nxt;
    logic                ready_nxt;
    logic                dbr_nxt;
    logic                irq_nxt;
    logic                issue_nxt;
    logic                busy_nxt;

    // A doorbell that is already high when reset releases counts as an edge,
    // because doorbell_d comes out of reset at 0.
    assign start = fpu_doorbell_w & ~doorbell_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (fpu_rst_w) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        lane_nxt  = lane_sel;
        last_nxt  = last_lane;
        timer_nxt = timer;
        flags_nxt = job_flags;
        tmo_nxt   = timeout_err;
        ready_nxt = fpu_ready;
        dbr_nxt   = 1'b0;
        irq_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (fpu_en) begin
                        state_nxt = ISSUE;
                        last_nxt  = fpu_simd ? fpu_simd_no_op : {LANE_W{1'b0}};
                        lane_nxt  = {LANE_W{1'b0}};
                        flags_nxt = 4'b0000;
                        tmo_nxt   = 1'b0;
                        ready_nxt = 1'b0;
                    end else begin
                        // Disabled FPU: still acknowledge so the host does not hang.
                        dbr_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                timer_nxt = 8'd0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A ready in the same cycle as the timeout condition wins.
                if (unit_ready) begin
                    flags_nxt = job_flags | unit_flags;
                    if (lane_sel == last_lane) begin
                        state_nxt = DONE;
                    end else begin
                        lane_nxt  = lane_sel + LANE_W'(1);
                        state_nxt = ISSUE;
                    end
                end else begin
                    timer_nxt = timer + 8'd1;
                    if (timer == TIMER_LAST) begin
                        state_nxt    = DONE;
                        tmo_nxt      = 1'b1;
                        flags_nxt[3] = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Completion outputs are registered on entry so they are visible in DONE.
        if (state_nxt == DONE) begin
            ready_nxt = 1'b1;
            dbr_nxt   = 1'b1;
            irq_nxt   = fpu_int_en;
        end else begin
            irq_nxt = 1'b0;
        end

        issue_nxt = (state_nxt == ISSUE);
        busy_nxt  = (state_nxt == ISSUE) || (state_nxt == WAIT);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            doorbell_d      <= 1'b0;
            last_lane       <= {LANE_W{1'b0}};
            timer           <= 8'd0;
            lane_sel        <= {LANE_W{1'b0}};
            job_flags       <= 4'b0000;
            timeout_err     <= 1'b0;
            fpu_ready       <= 1'b0;
            fpu_doorbell_r  <= 1'b0;
            fpu_interrupt_w <= 1'b0;
            issue           <= 1'b0;
            busy            <= 1'b0;
        end else if (fpu_rst_w) begin
            doorbell_d      <= 1'b0;
            last_lane       <= {LANE_W{1'b0}};
            timer           <= 8'd0;
            lane_sel        <= {LANE_W{1'b0}};
            job_flags       <= 4'b0000;
            timeout_err     <= 1'b0;
            fpu_ready       <= 1'b0;
            fpu_doorbell_r  <= 1'b0;
            fpu_interrupt_w <= 1'b0;
            issue           <= 1'b0;
            busy            <= 1'b0;
        end else begin
            doorbell_d      <= fpu_doorbell_w;
            last_lane       <= last_nxt;
            timer           <= timer_nxt;
            lane_sel        <= lane_nxt;
            job_flags       <= flags_nxt;
            timeout_err     <= tmo_nxt;
            fpu_ready       <= ready_nxt;
            fpu_doorbell_r  <= dbr_nxt;
            fpu_interrupt_w <= irq_nxt;
            issue           <= issue_nxt;
            busy            <= busy_nxt;
        end
    end

endmodule
